mem_req_ctrl: RTL and testbench

- Requester-side controller for the banked single-port scratchpad (`my_memory`); mirrors its addr/wr_en/rd_en/wr_data/rd_data interface from the initiator end.
- Accepts read/write requests from a datapath client over a valid/ready handshake and drives the memory's shared address and per-bank enables.
- Captures read data after the fixed memory read latency and returns it through a credit-protected response FIFO with valid/ready backpressure.

---
 rtl/mem_req_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Requester for the banked scratchpad: issues one read or write per accepted request.
// Latency: read accepted in cycle T is presented in cycle T+2 (empty FIFO); writes have no response.
// Backpressure: req_rdy is a credit check so FIFO entries plus the in-flight read never exceed RESP_DEPTH.
module mem_req_ctrl #(
  parameter int DATA_L     = 32,
  parameter int ADDR_L     = 10,
  parameter int N_BANKS    = 8,
  parameter int RD_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic                        req_wr,
  input  logic [ADDR_L-1:0]           req_addr,
  input  logic [N_BANKS-1:0]          req_bank_en,
  input  logic [N_BANKS*DATA_L-1:0]   req_wr_data,
  output logic                        resp_vld,
  input  logic                        resp_rdy,
  output logic [N_BANKS*DATA_L-1:0]   resp_data,
  output logic [N_BANKS-1:0]          resp_bank_en,
  output logic                        busy,
  output logic [ADDR_L-1:0]           mem_addr,
  output logic [N_BANKS*DATA_L-1:0]   mem_wr_data,
  output logic [N_BANKS-1:0]          mem_wr_en,
  output logic [N_BANKS-1:0]          mem_rd_en,
  input  logic [N_BANKS*DATA_L-1:0]   mem_rd_data
);

  localparam int W  = N_BANKS * DATA_L;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  // The memory read stage only advances on bank enable, so deeper pipelines cannot be tracked.
  if (RD_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "mem_req_ctrl: RD_LATENCY must be 1");
  end
  if (RESP_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "mem_req_ctrl: RESP_DEPTH must be >= 2");
  end

  logic                 inflight_q, inflight_d;
  logic [N_BANKS-1:0]   inflight_mask_q, inflight_mask_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_BANKS-1:0]   fifo_mask_q [RESP_DEPTH];
  logic [W-1:0]         fifo_data_q [RESP_DEPTH];

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [CW:0]          credit_used;
  logic [W-1:0]         cap_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign credit_used  = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign req_rdy      = !rst && (credit_used < (CW+1)'(RESP_DEPTH));
  assign accept       = req_vld && req_rdy;
  assign push         = inflight_q;
  assign resp_vld     = !rst && (cnt_q != '0);
  assign pop          = resp_vld && resp_rdy;
  assign busy         = !rst && (inflight_q || (cnt_q != '0));
  assign resp_data    = fifo_data_q[rd_ptr_q];
  assign resp_bank_en = fifo_mask_q[rd_ptr_q];

  // Idle cycles drive zeros so the memory sees no stale address or data.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = '0;
    mem_rd_en   = '0;
    mem_wr_data = '0;
    if (accept) begin
      mem_addr = req_addr;
      if (req_wr) begin
        mem_wr_en   = req_bank_en;
        mem_wr_data = req_wr_data;
      end else begin
        mem_rd_en = req_bank_en;
      end
    end
  end

  // Disabled banks hold stale read data, so they are masked off before buffering.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (inflight_mask_q[i]) cap_data[i*DATA_L +: DATA_L] = mem_rd_data[i*DATA_L +: DATA_L];
    end
  end

  always_comb begin
    inflight_d      = accept && !req_wr;
    inflight_mask_d = (accept && !req_wr) ? req_bank_en : inflight_mask_q;
    wr_ptr_d        = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d        = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d           = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_mask_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_mask_q <= inflight_mask_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mask_q[wr_ptr_q] <= inflight_mask_q;
      fifo_data_q[wr_ptr_q] <= cap_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == CW'(RESP_DEPTH)) && !pop));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a banked 1-cycle-latency memory model behind it.
module tb_mem_req_ctrl;
  localparam int DATA_L = 32;
  localparam int ADDR_L = 10;
  localparam int NB     = 8;
  localparam int W      = NB * DATA_L;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_vld, req_rdy, req_wr;
  logic [ADDR_L-1:0] req_addr;
  logic [NB-1:0]     req_bank_en;
  logic [W-1:0]      req_wr_data;
  logic              resp_vld, resp_rdy;
  logic [W-1:0]      resp_data;
  logic [NB-1:0]     resp_bank_en;
  logic              busy;
  logic [ADDR_L-1:0] mem_addr;
  logic [W-1:0]      mem_wr_data;
  logic [NB-1:0]     mem_wr_en, mem_rd_en;
  logic [W-1:0]      mem_rd_data = '0;

  int checks = 0;
  int errors = 0;
  int acc;

  logic [DATA_L-1:0] mem [NB][1024];

  always #5 clk = ~clk;

  mem_req_ctrl #(.DATA_L(DATA_L), .ADDR_L(ADDR_L), .N_BANKS(NB), .RD_LATENCY(1), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_bank_en(req_bank_en), .req_wr_data(req_wr_data),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_bank_en(resp_bank_en),
    .busy(busy), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
  );

  // Scratchpad model: write and read each advance only on their own bank enable.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_wr_en[b]) mem[b][mem_addr] = mem_wr_data[b*DATA_L +: DATA_L];
      if (mem_rd_en[b]) mem_rd_data[b*DATA_L +: DATA_L] <= mem[b][mem_addr];
    end
  end

  function automatic logic [DATA_L-1:0] exp_word(input int a, input int b);
    if (a == 5) return 32'hA000_0000 + DATA_L'(b);
    return 32'h1000_0000 + DATA_L'(a << 8) + DATA_L'(b);
  endfunction

  function automatic logic [W-1:0] exp_line(input int a, input logic [NB-1:0] m);
    logic [W-1:0] l;
    l = '0;
    for (int b = 0; b < NB; b++) if (m[b]) l[b*DATA_L +: DATA_L] = exp_word(a, b);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rd(input int a, input logic [NB-1:0] m);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = ADDR_L'(a); req_bank_en = m; req_wr_data = '0;
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++)
        mem[b][a] = 32'h1000_0000 + DATA_L'(a << 8) + DATA_L'(b);

    rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_bank_en = '0;
    req_wr_data = '0; resp_rdy = 1'b1;
    next();
    next();
    chk("rst_req_rdy", W'(req_rdy), W'(1'b0));
    rst = 1'b0;

    // 1: idle after reset
    @(negedge clk);
    chk("idle_req_rdy", W'(req_rdy), W'(1'b1));
    chk("idle_resp_vld", W'(resp_vld), W'(1'b0));
    chk("idle_busy", W'(busy), W'(1'b0));
    chk("idle_en", W'({mem_wr_en, mem_rd_en}), W'(0));
    chk("idle_addr", W'(mem_addr), W'(0));
    next();

    // 2: write addr 5 then read it back next cycle
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'd5; req_bank_en = 8'hFF;
    for (int b = 0; b < NB; b++) req_wr_data[b*DATA_L +: DATA_L] = 32'hA000_0000 + DATA_L'(b);
    @(negedge clk);
    chk("wr_en", W'(mem_wr_en), W'(8'hFF));
    chk("wr_rd_en", W'(mem_rd_en), W'(0));
    chk("wr_addr", W'(mem_addr), W'(5));
    chk("wr_data", mem_wr_data, exp_line(5, 8'hFF));
    next();
    drive_rd(5, 8'hFF);
    @(negedge clk);
    chk("rd_en", W'(mem_rd_en), W'(8'hFF));
    chk("rd_wr_data_zero", mem_wr_data, '0);
    next();
    req_vld = 1'b0;
    @(negedge clk);
    chk("rd_t1_resp_vld", W'(resp_vld), W'(1'b0));
    chk("rd_t1_busy", W'(busy), W'(1'b1));
    next();
    @(negedge clk);
    chk("rd_t2_resp_vld", W'(resp_vld), W'(1'b1));
    chk("rd_t2_data", resp_data, exp_line(5, 8'hFF));
    chk("rd_t2_mask", W'(resp_bank_en), W'(8'hFF));
    next();

    // 3: partial-mask read, upper lanes must read as zero
    drive_rd(5, 8'h0F);
    next();
    req_vld = 1'b0;
    next();
    @(negedge clk);
    chk("part_resp_vld", W'(resp_vld), W'(1'b1));
    chk("part_data", resp_data, exp_line(5, 8'h0F));
    chk("part_mask", W'(resp_bank_en), W'(8'h0F));
    next();

    // 4: stalled consumer, credit limit
    resp_rdy = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drive_rd(10 + acc, 8'hFF);
      @(negedge clk);
      if (req_rdy) acc++;
      next();
    end
    chk("credit_accepts", W'(acc), W'(4));
    req_vld = 1'b0; resp_rdy = 1'b1;
    @(negedge clk);
    chk("credit_full_rdy", W'(req_rdy), W'(1'b0));
    chk("drain0_data", resp_data, exp_line(10, 8'hFF));
    next();
    @(negedge clk);
    chk("credit_return_rdy", W'(req_rdy), W'(1'b1));
    chk("drain1_data", resp_data, exp_line(11, 8'hFF));
    next();
    @(negedge clk);
    chk("drain2_data", resp_data, exp_line(12, 8'hFF));
    next();
    @(negedge clk);
    chk("drain3_data", resp_data, exp_line(13, 8'hFF));
    next();
    @(negedge clk);
    chk("drained_vld", W'(resp_vld), W'(1'b0));
    chk("drained_busy", W'(busy), W'(1'b0));

    // 5: streaming reads, one response per cycle through wrapping pointers
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive_rd(k, 8'hFF);
      else req_vld = 1'b0;
      @(negedge clk);
      if (k < 16) chk($sformatf("stream_rdy_%0d", k), W'(req_rdy), W'(1'b1));
      if (k >= 2) begin
        chk($sformatf("stream_vld_%0d", k - 2), W'(resp_vld), W'(1'b1));
        chk($sformatf("stream_data_%0d", k - 2), resp_data, exp_line(k - 2, 8'hFF));
      end
      next();
    end
    @(negedge clk);
    chk("stream_end_vld", W'(resp_vld), W'(1'b0));
    next();

    // 6: asynchronous reset with two buffered responses and one in flight
    resp_rdy = 1'b0;
    drive_rd(20, 8'hFF); next();
    drive_rd(21, 8'hFF); next();
    drive_rd(22, 8'hFF); next();
    chk("pre_rst_vld", W'(resp_vld), W'(1'b1));
    chk("pre_rst_busy", W'(busy), W'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("rst_resp_vld", W'(resp_vld), W'(1'b0));
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_gated_en", W'({req_rdy, mem_rd_en, mem_wr_en}), W'(0));
    chk("rst_gated_addr", W'(mem_addr), W'(0));
    next();
    rst = 1'b0; req_vld = 1'b0; resp_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", W'(resp_vld), W'(1'b0));
    next();
    @(negedge clk);
    chk("post_rst_vld2", W'(resp_vld), W'(1'b0));
    chk("post_rst_busy", W'(busy), W'(1'b0));
    drive_rd(23, 8'h03);
    next();
    req_vld = 1'b0;
    next();
    @(negedge clk);
    chk("fresh_vld", W'(resp_vld), W'(1'b1));
    chk("fresh_data", resp_data, exp_line(23, 8'h03));
    chk("fresh_mask", W'(resp_bank_en), W'(8'h03));
    next();
    @(negedge clk);
    chk("fresh_only_one", W'(resp_vld), W'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
